// File: rtl/spi_lcd_pkg.sv
// Shared opcodes and decoder state encoding for the SPI display link receiver.
package spi_lcd_pkg;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2a;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2b;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2c;

  typedef enum logic [2:0] {
    LCD_IDLE,
    LCD_CASET,
    LCD_RASET,
    LCD_RAMWR,
    LCD_SKIP
  } lcd_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises the link into clk, detects
// sclk rising edges and assembles MSB-first bytes tagged with the dc level.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_cs,
  input  logic       lcd_dc,
  input  logic       lcd_sclk,
  input  logic       lcd_mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] cs_sync;
  logic [1:0] dc_sync;
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       sclk_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shift;

  // Two-flop synchronisers plus a delayed sclk copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      dc_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], lcd_cs};
      dc_sync   <= {dc_sync[0], lcd_dc};
      sclk_sync <= {sclk_sync[0], lcd_sclk};
      mosi_sync <= {mosi_sync[0], lcd_mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;

  // Shift in one bit per sclk rise; emit a tagged byte on the 8th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift <= {shift[5:0], mosi_sync[1]};
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, mosi_sync[1]};
          byte_dc    <= dc_sync[1];
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_sink.sv
// ST7789-style display sink: decodes CASET/RASET/RAMWR from the byte stream
// and emits one addressed RGB565 pixel per pair of RAMWR data bytes.
module spi_lcd_sink
  import spi_lcd_pkg::*;
#(
  parameter int W_COORD = 8,
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lcd_cs,
  input  logic               lcd_dc,
  input  logic               lcd_sclk,
  input  logic               lcd_mosi,
  output logic               pix_valid,
  output logic [W_COORD-1:0] pix_x,
  output logic [W_COORD-1:0] pix_y,
  output logic [15:0]        pix_data,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte
);

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_dc;

  lcd_state_t         state;
  logic [W_COORD-1:0] col_start, col_end, row_start, row_end;
  logic [W_COORD-1:0] ptr_x, ptr_y;
  logic [1:0]         param_cnt;
  logic [7:0]         param_hi;
  logic [W_COORD-1:0] param_start;
  logic [W_COORD-1:0] param_coord;
  logic [7:0]         pix_hold;
  logic               pix_phase;

  spi_byte_rx u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .lcd_cs     (lcd_cs),
    .lcd_dc     (lcd_dc),
    .lcd_sclk   (lcd_sclk),
    .lcd_mosi   (lcd_mosi),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  // Only the low W_COORD bits of each 16-bit parameter reach the window.
  assign param_coord = W_COORD'({param_hi, byte_data});

  // Command decoder, window registers, write pointer and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LCD_IDLE;
      col_start   <= '0;
      col_end     <= W_COORD'(WIDTH - 1);
      row_start   <= '0;
      row_end     <= W_COORD'(HEIGHT - 1);
      ptr_x       <= '0;
      ptr_y       <= '0;
      param_cnt   <= '0;
      param_hi    <= '0;
      param_start <= '0;
      pix_hold    <= '0;
      pix_phase   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
    end else begin
      pix_valid <= 1'b0;
      cmd_valid <= 1'b0;
      if (byte_valid && !byte_dc) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_data;
        param_cnt <= '0;
        pix_phase <= 1'b0;
        case (byte_data)
          LCD_CMD_CASET: state <= LCD_CASET;
          LCD_CMD_RASET: state <= LCD_RASET;
          LCD_CMD_RAMWR: begin
            state <= LCD_RAMWR;
            ptr_x <= col_start;
            ptr_y <= row_start;
          end
          default:       state <= LCD_SKIP;
        endcase
      end else if (byte_valid) begin
        case (state)
          LCD_CASET, LCD_RASET: begin
            param_cnt <= param_cnt + 2'd1;
            case (param_cnt)
              2'd0, 2'd2: param_hi    <= byte_data;
              2'd1:       param_start <= param_coord;
              default: begin
                if (state == LCD_CASET) begin
                  col_start <= param_start;
                  col_end   <= param_coord;
                end else begin
                  row_start <= param_start;
                  row_end   <= param_coord;
                end
                state <= LCD_SKIP;
              end
            endcase
          end
          LCD_RAMWR: begin
            if (!pix_phase) begin
              pix_hold  <= byte_data;
              pix_phase <= 1'b1;
            end else begin
              pix_phase <= 1'b0;
              pix_valid <= 1'b1;
              pix_x     <= ptr_x;
              pix_y     <= ptr_y;
              pix_data  <= {pix_hold, byte_data};
              if (ptr_x == col_end) begin
                ptr_x <= col_start;
                ptr_y <= (ptr_y == row_end) ? row_start : ptr_y + 1'b1;
              end else begin
                ptr_x <= ptr_x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_sink.sv
// Randomised and directed stimulus for spi_lcd_sink, checked against a
// command-level reference model of the display.
module tb_spi_lcd_sink;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int LAT  = 40;  // last sclk rise (driven at negedge) to pulse seen at negedge

  logic          clk = 1'b0;
  logic          rst, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi;
  logic          pix_valid, cmd_valid;
  logic [W-1:0]  pix_x, pix_y;
  logic [15:0]   pix_data;
  logic [7:0]    cmd_byte;

  spi_lcd_sink #(.W_COORD(W), .WIDTH(240), .HEIGHT(240)) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_cs    (lcd_cs),
    .lcd_dc    (lcd_dc),
    .lcd_sclk  (lcd_sclk),
    .lcd_mosi  (lcd_mosi),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pix[$];
  logic [7:0]  exp_cmd[$];
  time         last_rise_t = 0;

  // Reference model: mode 0 idle, 1 column window, 2 row window, 3 pixel write, 4 ignore.
  int          m_mode;
  int          cx0, cx1, ry0, ry1, px, py;
  logic [7:0]  m_par[$];
  logic [7:0]  m_pend[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    cx0 = 0; cx1 = 239; ry0 = 0; ry1 = 239;
    px = 0; py = 0;
    m_par.delete();
    m_pend.delete();
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] d);
    int s, e;
    if (!dc) begin
      exp_cmd.push_back(d);
      m_par.delete();
      m_pend.delete();
      case (d)
        8'h2a: m_mode = 1;
        8'h2b: m_mode = 2;
        8'h2c: begin m_mode = 3; px = cx0; py = ry0; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(d);
      if (m_par.size() == 4) begin
        s = (int'(m_par[0]) * 256 + int'(m_par[1])) & MASK;
        e = (int'(m_par[2]) * 256 + int'(m_par[3])) & MASK;
        if (m_mode == 1) begin cx0 = s; cx1 = e; end
        else begin ry0 = s; ry1 = e; end
        m_par.delete();
        m_mode = 4;
      end
    end else if (m_mode == 3) begin
      m_pend.push_back(d);
      if (m_pend.size() == 2) begin
        exp_pix.push_back({8'(px), 8'(py), m_pend[0], m_pend[1]});
        m_pend.delete();
        if (px == cx1) begin
          px = cx0;
          py = (py == ry1) ? ry0 : (py + 1) % (MASK + 1);
        end else begin
          px = (px + 1) % (MASK + 1);
        end
      end
    end
  endtask

  // One sclk period = 8 clk: 4 low, 4 high; all changes at negedge.
  task automatic send_bit(input logic dc, input logic b);
    @(negedge clk);
    lcd_sclk = 1'b0;
    lcd_mosi = b;
    lcd_dc   = dc;
    repeat (3) @(negedge clk);
    @(negedge clk);
    lcd_sclk    = 1'b1;
    last_rise_t = $time;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] d);
    logic [7:0] v;
    v = d;
    lcd_cs = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(dc, v[i]);
    model_byte(dc, d);
  endtask

  task automatic cs_pulse();
    repeat (4) @(negedge clk);
    lcd_cs = 1'b1;
    repeat (6) @(negedge clk);
    lcd_cs = 1'b0;
  endtask

  task automatic partial_byte(input int unsigned nbits);
    lcd_cs = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_pix_left"}, 32'(exp_pix.size()), 32'd0);
    check({tag, "_cmd_left"}, 32'(exp_cmd.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_x"},     32'(pix_x),     32'd0);
    check({tag, "_pix_y"},     32'(pix_y),     32'd0);
    check({tag, "_pix_data"},  32'(pix_data),  32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_byte"},  32'(cmd_byte),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    lcd_sclk = 1'b0;
    lcd_cs   = 1'b1;
    model_reset();
    @(posedge clk);
    #1 check_zero_outputs("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Pulse monitor: every pulse must match the oldest expectation and its latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        if (exp_pix.size() == 0) check("pix_unexpected_count", 32'(exp_pix.size()), 32'd1);
        else begin
          check("pix", {pix_x, pix_y, pix_data}, exp_pix.pop_front());
          check("pix_latency", 32'($time - last_rise_t), 32'(LAT));
        end
      end
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected_count", 32'(exp_cmd.size()), 32'd1);
        else begin
          check("cmd", 32'(cmd_byte), 32'(exp_cmd.pop_front()));
          check("cmd_latency", 32'($time - last_rise_t), 32'(LAT));
        end
      end
    end
  end

  initial begin
    int unsigned c0, c1, r0, r1, n;
    rst = 1'b1; lcd_cs = 1'b1; lcd_dc = 1'b0; lcd_sclk = 1'b0; lcd_mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("init");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single red pixel at the origin.
    send_byte(1'b0, 8'h2c);
    send_byte(1'b1, 8'hf8);
    send_byte(1'b1, 8'h00);
    drain("red");

    // Truncated CASET leaves the window alone.
    send_byte(1'b0, 8'h2a);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h07);
    send_byte(1'b0, 8'h2c);
    send_byte(1'b1, 8'hab);
    send_byte(1'b1, 8'hcd);
    drain("short_caset");

    // A held half pixel is dropped by an intervening command.
    send_byte(1'b0, 8'h2c);
    send_byte(1'b1, 8'hee);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h2c);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    drain("drop_half");

    // Partial byte discarded by CS high.
    partial_byte(5);
    cs_pulse();
    send_byte(1'b0, 8'h2c);
    drain("cs_abort");

    // 3x2 window, 7 pixels wraps back to the top-left corner.
    send_byte(1'b0, 8'h2a);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'h2b);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
    send_byte(1'b0, 8'h2c);
    for (int i = 0; i < 14; i++) send_byte(1'b1, 8'($urandom_range(0, 255)));
    drain("window");

    // Reset in the middle of a pixel and in the middle of a byte.
    send_byte(1'b0, 8'h2c);
    for (int i = 0; i < 7; i++) send_byte(1'b1, 8'($urandom_range(0, 255)));
    partial_byte(3);
    repeat (8) @(negedge clk);
    do_reset();
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'haa);
    drain("post_reset");

    // Random windows (one wrapping through 2^W), pixel bursts, stray commands, CS activity.
    for (int it = 0; it < 8; it++) begin
      c0 = $urandom_range(0, 255);
      c1 = (c0 + $urandom_range(0, 3)) & MASK;
      r0 = $urandom_range(0, 255);
      r1 = (r0 + $urandom_range(0, 2)) & MASK;
      if (it == 2) begin c0 = 254; c1 = 1; r0 = 255; r1 = 0; end
      send_byte(1'b0, 8'h2a);
      send_byte(1'b1, 8'($urandom_range(0, 255))); send_byte(1'b1, 8'(c0));
      send_byte(1'b1, 8'($urandom_range(0, 255))); send_byte(1'b1, 8'(c1));
      if ($urandom_range(0, 1) == 1) cs_pulse();
      send_byte(1'b0, 8'h2b);
      send_byte(1'b1, 8'($urandom_range(0, 255))); send_byte(1'b1, 8'(r0));
      send_byte(1'b1, 8'($urandom_range(0, 255))); send_byte(1'b1, 8'(r1));
      send_byte(1'b0, 8'h2c);
      n = $urandom_range(1, 12);
      for (int unsigned p = 0; p < n; p++) begin
        send_byte(1'b1, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) == 0) cs_pulse();
        send_byte(1'b1, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) begin
        partial_byte($urandom_range(1, 7));
        cs_pulse();
      end
      if ($urandom_range(0, 2) == 0) begin
        send_byte(1'b1, 8'($urandom_range(0, 255)));
        send_byte(1'b0, 8'($urandom_range(0, 255)));
        send_byte(1'b1, 8'($urandom_range(0, 255)));
      end
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
